// File: rtl/key_bank.sv
// key_bank: multi-channel push-button front end.
// Per channel: two-flop synchroniser, counter-based debouncer producing a
// debounced level plus press/release pulses, and an IDLE/HELD/LONG FSM that
// fires a long-press pulse after LONG_CYCLES of continuous press.
// Optional feature macro: KEY_BANK_REPEAT_EN adds an auto-repeat pulse every
// REPEAT_CYCLES while a channel stays in LONG; without it o_repeat is tied 0.
module key_bank #(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned DEB_CYCLES    = 7,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 1200000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_keys,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_neg,
  output logic [N_KEYS-1:0] o_pos,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_held
);

  // Elaboration-time parameter range checks
  if (N_KEYS < 1 || N_KEYS > 16) begin : g_bad_n_keys
    $error("key_bank: N_KEYS must be in 1..16");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("key_bank: DEB_CYCLES must be in 2..255");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("key_bank: LONG_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("key_bank: REPEAT_CYCLES must be at least 1");
  end

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  // The counter value seen on the edge where the next increment would reach
  // the target; acting on it makes the target edge the one that fires.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  // Two-flop synchroniser on every raw pin, idling at released (1)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_keys;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------
  logic [DW-1:0]     deb_cnt  [N_KEYS];
  logic [DW-1:0]     deb_next [N_KEYS];
  logic [N_KEYS-1:0] differ;
  logic [N_KEYS-1:0] flip;
  logic [N_KEYS-1:0] fall;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] level_next;

  // Count consecutive disagreeing samples; flip the level when the run is long enough
  always_comb begin
    differ     = '0;
    flip       = '0;
    fall       = '0;
    rise       = '0;
    level_next = o_level;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      deb_next[i] = '0;
      differ[i]   = sync2[i] != o_level[i];
      flip[i]     = differ[i] && (deb_cnt[i] == DEB_LAST);
      fall[i]     = flip[i] && o_level[i];
      rise[i]     = flip[i] && !o_level[i];
      if (flip[i]) begin
        level_next[i] = ~o_level[i];
      end else if (differ[i]) begin
        deb_next[i] = deb_cnt[i] + DW'(1);
      end
    end
  end

  // Debounced level, edge pulses and the registered any-held flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_level    <= '1;
      o_neg      <= '0;
      o_pos      <= '0;
      o_any_held <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      o_level    <= level_next;
      o_neg      <= fall;
      o_pos      <= rise;
      o_any_held <= ~&level_next;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        deb_cnt[i] <= deb_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press-duration FSM
  // ---------------------------------------------------------------------
  logic [1:0]        state      [N_KEYS];
  logic [1:0]        state_next [N_KEYS];
  logic [HW-1:0]     hold_cnt   [N_KEYS];
  logic [HW-1:0]     hold_next  [N_KEYS];
  logic [N_KEYS-1:0] long_hit;

  // FSM reacts to the same-cycle fall/rise events so it moves on the pulse edge
  always_comb begin
    long_hit = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_next[i] = state[i];
      hold_next[i]  = hold_cnt[i];
      case (state[i])
        ST_IDLE: begin
          if (fall[i]) begin
            state_next[i] = ST_HELD;
            hold_next[i]  = '0;
          end
        end
        ST_HELD: begin
          if (rise[i]) begin
            state_next[i] = ST_IDLE;
            hold_next[i]  = '0;
          end else if (hold_cnt[i] == HOLD_LAST) begin
            state_next[i] = ST_LONG;
            hold_next[i]  = HOLD_MAX;
            long_hit[i]   = 1'b1;
          end else begin
            hold_next[i] = hold_cnt[i] + HW'(1);
          end
        end
        ST_LONG: begin
          if (rise[i]) begin
            state_next[i] = ST_IDLE;
            hold_next[i]  = '0;
          end
        end
        default: begin
          state_next[i] = ST_IDLE;
          hold_next[i]  = '0;
        end
      endcase
    end
  end

  // FSM state, saturating hold counter and long-press pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_long <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]    <= ST_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      o_long <= long_hit;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]    <= state_next[i];
        hold_cnt[i] <= hold_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------
`ifdef KEY_BANK_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0]     rep_cnt  [N_KEYS];
  logic [RW-1:0]     rep_next [N_KEYS];
  logic [N_KEYS-1:0] rep_hit;

  // Counter runs only while staying in LONG; it is zero on every entry to LONG
  always_comb begin
    rep_hit = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      rep_next[i] = '0;
      if (state[i] == ST_LONG && !rise[i]) begin
        if (rep_cnt[i] == REP_LAST) begin
          rep_hit[i] = 1'b1;
        end else begin
          rep_next[i] = rep_cnt[i] + RW'(1);
        end
      end
    end
  end

  // Repeat counter and pulse register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_repeat <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      o_repeat <= rep_hit;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        rep_cnt[i] <= rep_next[i];
      end
    end
  end
`else
  // No repeat logic in this build
  always_comb begin
    o_repeat = '0;
  end
`endif

endmodule

// File: tb/tb_key_bank.sv
// Self-checking bench for key_bank (N_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20,
// REPEAT_CYCLES=5). Expected pulse events are queued when stimulus is driven
// and a negedge monitor pops and compares them against every observed pulse.
// Build with KEY_BANK_REPEAT_EN defined to also expect auto-repeat pulses.
module tb_key_bank;

  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;
  localparam int unsigned REP = 5;
  localparam int unsigned LAT = 2 + DEB;

  localparam int K_NEG  = 0;
  localparam int K_POS  = 1;
  localparam int K_LONG = 2;
  localparam int K_REP  = 3;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] keys;
  logic [NK-1:0] level;
  logic [NK-1:0] neg;
  logic [NK-1:0] pos;
  logic [NK-1:0] lng;
  logic [NK-1:0] rpt;
  logic          any_held;

  key_bank #(
    .N_KEYS        (NK),
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LNG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_keys     (keys),
    .o_level    (level),
    .o_neg      (neg),
    .o_pos      (pos),
    .o_long     (lng),
    .o_repeat   (rpt),
    .o_any_held (any_held)
  );

  typedef struct {
    int unsigned   cyc;
    int            kind;
    logic [NK-1:0] mask;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 0;
  string       kname[4] = '{"neg", "pos", "long", "repeat"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle, each pulse kind is matched against queued events
  always @(negedge clk) begin : monitor
    logic [NK-1:0] got;
    logic [NK-1:0] want;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        case (k)
          K_NEG:   got = neg;
          K_POS:   got = pos;
          K_LONG:  got = lng;
          default: got = rpt;
        endcase
        want = '0;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
          if (exp_q[j].cyc == cyc && exp_q[j].kind == k) begin
            want = want | exp_q[j].mask;
            exp_q.delete(j);
          end
        end
        if (got !== '0 || want !== '0) begin
          n_checks++;
          if (got !== want) begin
            n_fail++;
            $display("FAIL sb_%s cycle=%0d got=%b want=%b", kname[k], cyc, got, want);
          end
        end
      end
    end
  end

  task automatic push(input int kind, input int unsigned c, input logic [NK-1:0] mask);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  // Advance to #1 after edge number c (returns at once if already there)
  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_level got=%h want=f", level);
    end
    n_checks++;
    if ({neg, pos, lng, rpt, any_held} !== '0) begin
      n_fail++;
      $display("FAIL reset_pulses got neg=%b pos=%b long=%b rep=%b any=%b want all 0",
               neg, pos, lng, rpt, any_held);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_idle();
    int unsigned t0;
    t0 = cyc;
    keys = '1;
    wait_cyc(t0 + 50);
    n_checks++;
    if (level !== 4'hF || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_level got=%h any=%b want=f any=0", level, any_held);
    end
  endtask

  task automatic test_press();
    int unsigned t0;
    int unsigned t1;
    t0 = cyc;
    keys[0] = 1'b0;
    push(K_NEG, t0 + LAT, 4'b0001);
    wait_cyc(t0 + LAT - 1);
    n_checks++;
    if (level !== 4'hF) begin
      n_fail++;
      $display("FAIL press_early got=%h want=f", level);
    end
    wait_cyc(t0 + LAT);
    n_checks++;
    if (level !== 4'hE || any_held !== 1'b1 || neg !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_edge got level=%h any=%b neg=%b want e 1 0001", level, any_held, neg);
    end
    wait_cyc(t0 + LAT + 1);
    n_checks++;
    if (neg !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_one_cycle got neg=%b want 0000", neg);
    end
    wait_cyc(t0 + 10);
    t1 = cyc;
    keys = '1;
    push(K_POS, t1 + LAT, 4'b0001);
    wait_cyc(t1 + LAT);
    n_checks++;
    if (level !== 4'hF || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL press_release got level=%h any=%b want f 0", level, any_held);
    end
    wait_cyc(t1 + LAT + 4);
  endtask

  task automatic test_glitch();
    int unsigned t0;
    t0 = cyc;
    keys[1] = 1'b0;
    wait_cyc(t0 + DEB - 1);
    keys = '1;
    wait_cyc(t0 + LAT);
    n_checks++;
    if (level !== 4'hF) begin
      n_fail++;
      $display("FAIL glitch_level got=%h want=f", level);
    end
    wait_cyc(t0 + 15);
  endtask

  task automatic test_min_press();
    int unsigned t0;
    t0 = cyc;
    keys[1] = 1'b0;
    wait_cyc(t0 + DEB);
    keys = '1;
    push(K_NEG, t0 + LAT, 4'b0010);
    push(K_POS, t0 + LAT + DEB, 4'b0010);
    wait_cyc(t0 + LAT + DEB);
    n_checks++;
    if (level !== 4'hF) begin
      n_fail++;
      $display("FAIL min_press_level got=%h want=f", level);
    end
    wait_cyc(t0 + LAT + DEB + 4);
  endtask

  task automatic test_long();
    int unsigned t0;
    t0 = cyc;
    keys[2] = 1'b0;
    push(K_NEG, t0 + LAT, 4'b0100);
    push(K_LONG, t0 + LAT + LNG, 4'b0100);
`ifdef KEY_BANK_REPEAT_EN
    for (int unsigned c = t0 + LAT + LNG + REP; c < t0 + 40 + LAT; c += REP) begin
      push(K_REP, c, 4'b0100);
    end
`endif
    wait_cyc(t0 + LAT + LNG);
    n_checks++;
    if (lng !== 4'b0100) begin
      n_fail++;
      $display("FAIL long_pulse got=%b want=0100", lng);
    end
    wait_cyc(t0 + 40);
    keys = '1;
    push(K_POS, t0 + 40 + LAT, 4'b0100);
    wait_cyc(t0 + 40 + LAT);
    n_checks++;
    if (level !== 4'hF) begin
      n_fail++;
      $display("FAIL long_release got=%h want=f", level);
    end
    wait_cyc(t0 + 40 + LAT + 4);
  endtask

  task automatic test_simul();
    int unsigned t0;
    int unsigned t1;
    t0 = cyc;
    keys = 4'b0110;
    push(K_NEG, t0 + LAT, 4'b1001);
    wait_cyc(t0 + LAT);
    n_checks++;
    if (neg !== 4'b1001 || level !== 4'b0110) begin
      n_fail++;
      $display("FAIL simul_press got neg=%b level=%b want 1001 0110", neg, level);
    end
    wait_cyc(t0 + LAT + 2);
    t1 = cyc;
    keys = '1;
    push(K_POS, t1 + LAT, 4'b1001);
    wait_cyc(t1 + LAT + 2);
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    t0 = cyc;
    keys = 4'b1110;
    push(K_NEG, t0 + LAT, 4'b0001);
    wait_cyc(t0 + 10);
    rst_n = 1'b0;
    wait_cyc(t0 + 11);
    n_checks++;
    if (level !== 4'hF || any_held !== 1'b0 || neg !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_state got level=%h any=%b neg=%b want f 0 0000", level, any_held, neg);
    end
    rst_n = 1'b1;
    push(K_NEG, t0 + 11 + LAT, 4'b0001);
    wait_cyc(t0 + 11 + LAT);
    n_checks++;
    if (level !== 4'hE) begin
      n_fail++;
      $display("FAIL midreset_refire got level=%h want=e", level);
    end
    wait_cyc(t0 + 20);
    keys = '1;
    push(K_POS, t0 + 20 + LAT, 4'b0001);
    wait_cyc(t0 + 20 + LAT + 4);
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = '1;
    test_reset();
    test_idle();
    test_press();
    test_glitch();
    test_min_press();
    test_long();
    test_simul();
    test_reset_mid();
    wait_cyc(cyc + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d pending events want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
